layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/layer_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_layer_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
//
// Sequences one fully-connected neural-network layer through a shared
// multiply-accumulate datapath. For each neuron it clears the accumulator,
// then issues one weight/input read per input. Each accepted product is added
// one cycle later because of the multiplier latency. After a drain cycle it
// offers the finished accumulator to the activation stage. The layer ends
// with a one-cycle done pulse.
//
// Parameters
//   AW      weight-memory address width
//   MAXIN   maximum inputs per neuron
//   MAXNEU  maximum neurons per layer
//
// Ports
//   Clock     single clock, rising edge
//   Rst       synchronous active-low reset
//   Start     run one layer (sampled only while idle)
//   abort     return to idle at the next edge, without done
//   num_in    inputs per neuron (1..MAXIN)
//   num_neu   neurons in the layer (1..MAXNEU)
//   w_base    first weight address of the layer
//   hold      stall issue (for example, while training rewrites the weights)
//   af_ready  activation stage takes the current accumulator
//   rd_en     weight/input read strobe
//   w_addr    weight address
//   in_idx    input-vector index
//   acc_clr   clear the shared accumulator
//   acc_en    add the multiplier result into the accumulator
//   af_valid  accumulator is complete for neuron neu_idx
//   neu_idx   current neuron
//   busy      layer in progress
//   done      one-cycle end-of-layer pulse
//   err_cfg   one-cycle rejected-configuration pulse
// -----------------------------------------------------------------------------
module layer_sequencer #(
  parameter int AW     = 8,
  parameter int MAXIN  = 30,
  parameter int MAXNEU = 5
) (
  input  logic          Clock,
  input  logic          Rst,
  input  logic          Start,
  input  logic          abort,
  input  logic [4:0]    num_in,
  input  logic [2:0]    num_neu,
  input  logic [AW-1:0] w_base,
  input  logic          hold,
  input  logic          af_ready,
  output logic          rd_en,
  output logic [AW-1:0] w_addr,
  output logic [4:0]    in_idx,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          af_valid,
  output logic [2:0]    neu_idx,
  output logic          busy,
  output logic          done,
  output logic          err_cfg
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_ACT,
    S_DONE
  } state_t;

  // The range check needs headroom for the address span. A 5-bit count
  // times a 3-bit count fits in 8 bits, plus one carry bit for the add.
  localparam int          EW       = AW + 9;
  localparam logic [4:0]  MAXIN_V  = 5'(MAXIN);
  localparam logic [2:0]  MAXNEU_V = 3'(MAXNEU);

  state_t        state;
  logic [4:0]    cfg_in;
  logic [2:0]    cfg_neu;
  logic [EW-1:0] span_end;
  logic          cfg_ok;

  // One past the last weight address the layer would touch. It may equal
  // 2^AW exactly, because the last address used is then 2^AW-1.
  assign span_end = EW'(w_base) + EW'(num_in) * EW'(num_neu);

  assign cfg_ok = (num_in  != '0) && (num_in  <= MAXIN_V)  &&
                  (num_neu != '0) && (num_neu <= MAXNEU_V) &&
                  (span_end <= (EW'(1) << AW));

  // The read strobe reacts to hold in the same cycle, so a stalled cycle
  // never issues. Gating with abort and Rst keeps acc_en, which is rd_en
  // delayed by one cycle, from firing after the sequence has been discarded.
  assign rd_en = Rst && !abort && !hold && (state == S_ISSUE);

  // in_idx is the input counter i, neu_idx is the neuron counter n, and
  // w_addr advances by one per issued read. Weights of consecutive neurons
  // are contiguous, so w_base + n*num_in + i needs no multiplier here.
  // NOTE: every register in this block uses non-blocking assignments, so
  // all of them update together from the pre-edge values. Where a pulse
  // gets a default at the top, a later assignment in the same pass wins.
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      state    <= S_IDLE;
      cfg_in   <= '0;
      cfg_neu  <= '0;
      w_addr   <= '0;
      in_idx   <= '0;
      neu_idx  <= '0;
      acc_clr  <= 1'b0;
      acc_en   <= 1'b0;
      af_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_cfg  <= 1'b0;
    end else begin
      acc_clr <= 1'b0;
      done    <= 1'b0;
      err_cfg <= 1'b0;
      acc_en  <= rd_en;

      if (abort) begin
        state    <= S_IDLE;
        w_addr   <= '0;
        in_idx   <= '0;
        neu_idx  <= '0;
        af_valid <= 1'b0;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (Start) begin
              if (cfg_ok) begin
                cfg_in  <= num_in;
                cfg_neu <= num_neu;
                w_addr  <= w_base;
                neu_idx <= '0;
                busy    <= 1'b1;
                acc_clr <= 1'b1;
                state   <= S_CLEAR;
              end else begin
                err_cfg <= 1'b1;
              end
            end
          end

          S_CLEAR: begin
            in_idx <= '0;
            state  <= S_ISSUE;
          end

          S_ISSUE: begin
            if (!hold) begin
              w_addr <= w_addr + AW'(1);
              // The index stays on the last input, so in_idx never reads
              // num_in.
              if (in_idx == cfg_in - 5'd1) begin
                state <= S_DRAIN;
              end else begin
                in_idx <= in_idx + 5'd1;
              end
            end
          end

          S_DRAIN: begin
            af_valid <= 1'b1;
            state    <= S_ACT;
          end

          S_ACT: begin
            if (af_ready) begin
              af_valid <= 1'b0;
              if (neu_idx == cfg_neu - 3'd1) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                neu_idx <= neu_idx + 3'd1;
                acc_clr <= 1'b1;
                state   <= S_CLEAR;
              end
            end
          end

          S_DONE: begin
            w_addr  <= '0;
            in_idx  <= '0;
            neu_idx <= '0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_layer_sequencer
//
// Cycle numbering: cycle 0 is the cycle in which Start is applied. Cycle t is
// the cycle that follows the t-th rising edge after that. Inputs are driven
// at the falling edge, and outputs are sampled 1 time unit later.
//
// Before each layer the expected per-cycle behaviour is laid out as a
// timeline. The timeline is built by walking neurons and inputs and
// skipping the stall cycles given by the hold / af_ready schedules.
// -----------------------------------------------------------------------------
module tb_layer_sequencer;

  localparam int AW   = 8;
  localparam int MAXC = 1024;

  logic          Clock = 1'b0;
  logic          Rst;
  logic          Start;
  logic          abort;
  logic [4:0]    num_in;
  logic [2:0]    num_neu;
  logic [AW-1:0] w_base;
  logic          hold;
  logic          af_ready;
  logic          rd_en;
  logic [AW-1:0] w_addr;
  logic [4:0]    in_idx;
  logic          acc_clr;
  logic          acc_en;
  logic          af_valid;
  logic [2:0]    neu_idx;
  logic          busy;
  logic          done;
  logic          err_cfg;

  int n_pass  = 0;
  int n_total = 0;

  always #5 Clock = ~Clock;

  layer_sequencer #(.AW(AW), .MAXIN(30), .MAXNEU(5)) dut (
    .Clock    (Clock),
    .Rst      (Rst),
    .Start    (Start),
    .abort    (abort),
    .num_in   (num_in),
    .num_neu  (num_neu),
    .w_base   (w_base),
    .hold     (hold),
    .af_ready (af_ready),
    .rd_en    (rd_en),
    .w_addr   (w_addr),
    .in_idx   (in_idx),
    .acc_clr  (acc_clr),
    .acc_en   (acc_en),
    .af_valid (af_valid),
    .neu_idx  (neu_idx),
    .busy     (busy),
    .done     (done),
    .err_cfg  (err_cfg)
  );

  // Stall schedules, indexed by cycle
  bit hold_s  [MAXC];
  bit ready_s [MAXC];

  // Expected timeline
  bit e_rd   [MAXC];
  bit e_clr  [MAXC];
  bit e_af   [MAXC];
  bit e_done [MAXC];
  bit e_busy [MAXC];
  int e_addr [MAXC];
  int e_idx  [MAXC];
  int e_neu  [MAXC];
  int t_done_exp;
  int t_end;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, wanted %0h", tag, obs, exp);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".rd_en"},    32'(rd_en),    0);
    chk({tag, ".w_addr"},   32'(w_addr),   0);
    chk({tag, ".in_idx"},   32'(in_idx),   0);
    chk({tag, ".acc_clr"},  32'(acc_clr),  0);
    chk({tag, ".acc_en"},   32'(acc_en),   0);
    chk({tag, ".af_valid"}, 32'(af_valid), 0);
    chk({tag, ".neu_idx"},  32'(neu_idx),  0);
    chk({tag, ".busy"},     32'(busy),     0);
    chk({tag, ".done"},     32'(done),     0);
    chk({tag, ".err_cfg"},  32'(err_cfg),  0);
  endtask

  task automatic clear_stalls();
    for (int k = 0; k < MAXC; k++) begin
      hold_s[k]  = 1'b0;
      ready_s[k] = 1'b1;
    end
  endtask

  task automatic random_stalls();
    for (int k = 0; k < MAXC; k++) begin
      hold_s[k]  = (k < 600) ? ($urandom_range(0, 4) == 0) : 1'b0;
      ready_s[k] = (k < 600) ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  // Expected timeline of one layer: per neuron, one clear cycle, one issue
  // per input (with held cycles inserted), one drain cycle, then the
  // activation offer until it is taken. The done cycle comes last.
  task automatic build(input int ni, input int nn, input int base);
    int t;
    for (int k = 0; k < MAXC; k++) begin
      e_rd[k] = 0; e_clr[k] = 0; e_af[k] = 0; e_done[k] = 0; e_busy[k] = 0;
      e_addr[k] = 0; e_idx[k] = 0; e_neu[k] = 0;
    end
    t = 1;
    for (int j = 0; j < nn; j++) begin
      e_busy[t] = 1; e_clr[t] = 1; t++;
      for (int k = 0; k < ni; k++) begin
        while (hold_s[t]) begin e_busy[t] = 1; t++; end
        e_busy[t] = 1; e_rd[t] = 1; e_addr[t] = base + j * ni + k; e_idx[t] = k; t++;
      end
      e_busy[t] = 1; t++;
      while (!ready_s[t]) begin e_busy[t] = 1; e_af[t] = 1; e_neu[t] = j; t++; end
      e_busy[t] = 1; e_af[t] = 1; e_neu[t] = j; t++;
    end
    e_busy[t] = 1; e_done[t] = 1;
    t_done_exp = t;
    t_end = t + 1;
  endtask

  task automatic check_cycle(input int t);
    chk($sformatf("rd_en@%0d", t),    32'(rd_en),    32'(e_rd[t]));
    chk($sformatf("acc_en@%0d", t),   32'(acc_en),   32'(e_rd[t-1]));
    chk($sformatf("acc_clr@%0d", t),  32'(acc_clr),  32'(e_clr[t]));
    chk($sformatf("af_valid@%0d", t), 32'(af_valid), 32'(e_af[t]));
    chk($sformatf("busy@%0d", t),     32'(busy),     32'(e_busy[t]));
    chk($sformatf("done@%0d", t),     32'(done),     32'(e_done[t]));
    chk($sformatf("err_cfg@%0d", t),  32'(err_cfg),  0);
    if (e_rd[t]) begin
      chk($sformatf("w_addr@%0d", t), 32'(w_addr), e_addr[t]);
      chk($sformatf("in_idx@%0d", t), 32'(in_idx), e_idx[t]);
    end
    if (e_af[t]) chk($sformatf("neu_idx@%0d", t), 32'(neu_idx), e_neu[t]);
  endtask

  // Runs one layer to completion and returns the cycle where done was seen
  // (-1 if never). With jitter set, Start and the config inputs are changed
  // at random while the layer runs.
  task automatic run_layer(input int ni, input int nn, input int base,
                           input bit jitter, output int t_obs);
    build(ni, nn, base);
    @(negedge Clock);
    Start = 1'b1; num_in = 5'(ni); num_neu = 3'(nn); w_base = AW'(base);
    hold = hold_s[0]; af_ready = ready_s[0];
    #1 chk("busy@0", 32'(busy), 0);
    t_obs = -1;
    for (int t = 1; t <= t_end; t++) begin
      @(negedge Clock);
      hold = hold_s[t]; af_ready = ready_s[t];
      if (jitter && t < t_end) begin
        Start = 1'($urandom); num_in = 5'($urandom); num_neu = 3'($urandom);
        w_base = AW'($urandom);
      end else begin
        Start = 1'b0;
      end
      #1;
      check_cycle(t);
      if (done === 1'b1 && t_obs < 0) t_obs = t;
    end
    Start = 1'b0; hold = 1'b0; af_ready = 1'b1;
  endtask

  task automatic try_bad(input int ni, input int nn, input int base);
    @(negedge Clock);
    Start = 1'b1; num_in = 5'(ni); num_neu = 3'(nn); w_base = AW'(base);
    #1 chk("bad.err_cfg@0", 32'(err_cfg), 0);
    @(negedge Clock);
    Start = 1'b0;
    #1;
    chk("bad.err_cfg@1", 32'(err_cfg), 1);
    chk("bad.busy@1",    32'(busy),    0);
    chk("bad.rd_en@1",   32'(rd_en),   0);
    @(negedge Clock);
    #1;
    chk("bad.err_cfg@2", 32'(err_cfg), 0);
    chk("bad.busy@2",    32'(busy),    0);
    chk("bad.rd_en@2",   32'(rd_en),   0);
  endtask

  // 30x5 layer interrupted at i=7, n=3, by abort (use_rst=0) or by reset
  task automatic run_abort(input bit use_rst);
    int ta;
    clear_stalls();
    build(30, 5, 0);
    ta = 1 + 3 * 33 + 1 + 7;
    @(negedge Clock);
    Start = 1'b1; num_in = 5'd30; num_neu = 3'd5; w_base = '0;
    for (int t = 1; t < ta; t++) begin
      @(negedge Clock);
      Start = 1'b0;
      #1 check_cycle(t);
    end
    @(negedge Clock);
    if (use_rst) Rst = 1'b0; else abort = 1'b1;
    #1;
    chk("abort.w_addr",  32'(w_addr),  97);
    chk("abort.in_idx",  32'(in_idx),  7);
    chk("abort.neu_idx", 32'(neu_idx), 3);
    chk("abort.busy",    32'(busy),    1);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      Rst = 1'b1; abort = 1'b0;
      #1 check_zero(use_rst ? "after_rst" : "after_abort");
    end
  endtask

  initial begin
    int td;
    int ni, nn, base;
    bit ok;

    Rst = 1'b0; Start = 1'b0; abort = 1'b0; hold = 1'b0; af_ready = 1'b1;
    num_in = '0; num_neu = '0; w_base = '0;
    repeat (2) @(negedge Clock);
    #1 check_zero("reset");
    @(negedge Clock);
    Rst = 1'b1;

    // Full-size layer at address 0
    clear_stalls();
    run_layer(30, 5, 0, 1'b0, td);
    chk("done_cycle_30x5", td, 166);

    // Small layer at a nonzero base
    clear_stalls();
    run_layer(5, 3, 150, 1'b0, td);
    chk("done_cycle_5x3", td, 25);

    // Three held cycles at i=10, n=2
    clear_stalls();
    hold_s[78] = 1'b1; hold_s[79] = 1'b1; hold_s[80] = 1'b1;
    run_layer(30, 5, 0, 1'b0, td);
    chk("done_cycle_hold", td, 169);

    // af_ready low for four cycles at n=1
    clear_stalls();
    for (int k = 66; k < 70; k++) ready_s[k] = 1'b0;
    run_layer(30, 5, 0, 1'b0, td);
    chk("done_cycle_afready", td, 170);

    // Rejected configurations
    try_bad(0, 5, 0);
    try_bad(30, 5, 200);

    // Abort and reset mid-layer, each followed by a normal run
    run_abort(1'b0);
    clear_stalls();
    run_layer(4, 2, 10, 1'b0, td);
    chk("done_after_abort", td, 2 * 7 + 1);
    run_abort(1'b1);
    clear_stalls();
    run_layer(1, 1, 255, 1'b0, td);
    chk("done_after_rst", td, 5);

    // Random configurations, stalls and mid-layer input changes
    for (int r = 0; r < 16; r++) begin
      ni   = $urandom_range(0, 31);
      nn   = $urandom_range(0, 7);
      base = $urandom_range(0, 255);
      ok   = (ni >= 1) && (ni <= 30) && (nn >= 1) && (nn <= 5) && (base + ni * nn <= 256);
      if (ok) begin
        random_stalls();
        run_layer(ni, nn, base, 1'b1, td);
        chk($sformatf("done_cycle_rand%0d", r), td, t_done_exp);
      end else begin
        try_bad(ni, nn, base);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
